// File: rtl/rf_write_arbiter.sv
// ============================================================================
//  Module   : rf_write_arbiter
//  Brief    : Round-robin arbiter sharing one register-file write port among
//             NUM_REQ writeback sources. The granted write is registered into
//             an output stage that drives the register file, and a one-hot
//             pending map of the in-flight destination is exposed for hazard
//             and forwarding logic.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_write_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32
) (
    input  logic                          clk_i,
    input  logic                          reset_ni,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic [NUM_REQ*ADDR_W-1:0]     req_addr_i,
    input  logic [NUM_REQ*DATA_W-1:0]     req_data_i,
    output logic                          rf_write_en_o,
    output logic [ADDR_W-1:0]             rf_write_addr_o,
    output logic [DATA_W-1:0]             rf_write_data_o,
    output logic [(2**ADDR_W)-1:0]        pending_o,
    output logic [$clog2(NUM_REQ)-1:0]    grant_idx_o
);

    localparam int IDX_W = $clog2(NUM_REQ);
    // One extra bit so ptr + offset can exceed NUM_REQ-1 before wrapping.
    localparam int CNT_W = IDX_W + 1;

    // Round-robin pointer: the requester with highest priority this cycle.
    logic [IDX_W-1:0]  ptr_q;
    logic [IDX_W-1:0]  ptr_d;

    // Output stage registers.
    logic              wen_q;
    logic              wen_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;
    logic [IDX_W-1:0]  gidx_q;
    logic [IDX_W-1:0]  gidx_d;

    // Arbitration results.
    logic              found;
    logic [IDX_W-1:0]  sel;
    logic [CNT_W-1:0]  cand;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic [(2**ADDR_W)-1:0] pending;

    // Scan requesters starting at ptr_q, wrapping modulo NUM_REQ; first valid wins.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr_q} + CNT_W'(i);
            if (cand >= CNT_W'(NUM_REQ)) begin
                cand = cand - CNT_W'(NUM_REQ);
            end
            if (!found && req_valid_i[cand[IDX_W-1:0]]) begin
                found = 1'b1;
                sel   = cand[IDX_W-1:0];
            end
        end
    end

    // One-hot ready to the winner; the output stage never stalls, so ready
    // is simply "this requester won the scan".
    always_comb begin
        req_ready_o = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            req_ready_o[k] = found && (sel == IDX_W'(k));
        end
    end

    // Payload of the winning requester.
    always_comb begin
        sel_addr = req_addr_i[sel*ADDR_W +: ADDR_W];
        sel_data = req_data_i[sel*DATA_W +: DATA_W];
    end

    // Next-state for pointer and output stage. Writes to x0 are consumed and
    // advance the pointer but never raise the write enable.
    always_comb begin
        ptr_d  = ptr_q;
        wen_d  = 1'b0;
        addr_d = addr_q;
        data_d = data_q;
        gidx_d = gidx_q;
        if (found) begin
            ptr_d  = (sel == IDX_W'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
            wen_d  = (sel_addr != '0);
            addr_d = sel_addr;
            data_d = sel_data;
            gidx_d = sel;
        end
    end

    // State registers; reset drops any in-flight write immediately.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            ptr_q  <= '0;
            wen_q  <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            gidx_q <= '0;
        end else begin
            ptr_q  <= ptr_d;
            wen_q  <= wen_d;
            addr_q <= addr_d;
            data_q <= data_d;
            gidx_q <= gidx_d;
        end
    end

    // One-hot map of the destination currently being written.
    always_comb begin
        pending = '0;
        if (wen_q) begin
            pending[addr_q] = 1'b1;
        end
    end

    assign rf_write_en_o   = wen_q;
    assign rf_write_addr_o = addr_q;
    assign rf_write_data_o = data_q;
    assign grant_idx_o     = gidx_q;
    assign pending_o       = pending;

endmodule

`default_nettype wire
